// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: op codes, FSM
// states and the Booth digit set with its window decoder.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  typedef enum logic [2:0] {
    BD_ZERO = 3'b000,
    BD_P1   = 3'b001,
    BD_P2   = 3'b010,
    BD_M1   = 3'b011,
    BD_M2   = 3'b100
  } booth_dig_e;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_dig_e booth_decode(input logic [2:0] win);
    booth_dig_e dig;
    case (win)
      3'b001, 3'b010: dig = BD_P1;
      3'b011:         dig = BD_P2;
      3'b100:         dig = BD_M2;
      3'b101, 3'b110: dig = BD_M1;
      default:        dig = BD_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product generator: selects 0, +/-m or +/-2m of the
// (XLEN+2)-bit extended multiplicand as an (XLEN+3)-bit signed value.
module booth_r4_enc
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      win_i,
  input  logic [XLEN+1:0] mcand_i,
  output logic [XLEN+2:0] pp_o
);

  logic [XLEN+2:0] m1_s;
  logic [XLEN+2:0] m2_s;
  booth_dig_e      dig_s;

  assign m1_s  = {mcand_i[XLEN+1], mcand_i};
  assign m2_s  = {mcand_i, 1'b0};
  assign dig_s = booth_decode(win_i);

  always_comb begin
    pp_o = '0;
    case (dig_s)
      BD_P1:   pp_o = m1_s;
      BD_P2:   pp_o = m2_s;
      BD_M1:   pp_o = -m1_s;
      BD_M2:   pp_o = -m2_s;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU. One Booth digit
// per cycle is added into the top of a right-shifting accumulator.
module mul_booth_seq
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [1:0]       op_sel_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int N     = XLEN / 2 + 1;
  localparam int CNT_W = $clog2(N);
  localparam int EXT_W = XLEN + 2;
  localparam int ACC_W = 2 * EXT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXT_W-1:0] a_q, a_d;
  logic [EXT_W:0]   b_q, b_d;
  mul_op_e          op_q, op_d;
  logic [TAG_W-1:0] tagc_q, tagc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [XLEN+2:0]  pp_s;
  logic [XLEN+3:0]  sum_s;
  logic [ACC_W-1:0] step_acc_s;
  logic [EXT_W-1:0] a_ext_s;
  logic [EXT_W-1:0] b_ext_s;
  logic             acc_unused_s;

  booth_r4_enc #(.XLEN(XLEN)) u_enc (
    .win_i   (b_q[2:0]),
    .mcand_i (a_q),
    .pp_o    (pp_s)
  );

  // a is signed unless MULHU; b is signed only for MUL/MULH (op_sel[1]==0).
  assign a_ext_s = {{2{a_i[XLEN-1] & (op_sel_i != 2'b11)}}, a_i};
  assign b_ext_s = {{2{b_i[XLEN-1] & ~op_sel_i[1]}}, b_i};

  // Add the digit's partial product at the top, then arithmetic shift right by 2.
  assign sum_s      = {{2{acc_q[ACC_W-1]}}, acc_q[ACC_W-1:EXT_W]} + {pp_s[XLEN+2], pp_s};
  assign step_acc_s = {sum_s, acc_q[EXT_W-1:2]};
  assign acc_unused_s = ^acc_q[1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    tagc_d   = tagc_q;
    acc_d    = acc_q;
    result_d = result_q;
    tag_d    = tag_q;
    case (state_q)
      IDLE: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (in_valid_i) begin
          a_d     = a_ext_s;
          b_d     = {b_ext_s, 1'b0};
          op_d    = mul_op_e'(op_sel_i);
          tagc_d  = tag_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (kill_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = step_acc_s;
          b_d   = {2'b00, b_q[EXT_W:2]};
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            state_d  = DONE;
            result_d = (op_q == MUL) ? step_acc_s[XLEN-1:0] : step_acc_s[2*XLEN-1:XLEN];
            tag_d    = tagc_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (kill_i || out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= MUL;
      tagc_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tagc_q      <= tagc_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign tag_o       = tag_q;

endmodule
